dut_debug_ctrl: RTL and testbench



---
 rtl/dbg_pkg.sv | 27 ++
 rtl/dbg_bkpt_match.sv | 25 ++
 rtl/dut_debug_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dut_debug_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared types and field positions for the DUT run-control block.
package dbg_pkg;

    typedef enum logic [1:0] {
        StHalt = 2'd0,
        StRun  = 2'd1,
        StRunN = 2'd2,
        StStep = 2'd3
    } dbg_state_e;

    localparam logic [1:0] ReasonNone = 2'd0;
    localparam logic [1:0] ReasonStep = 2'd1;
    localparam logic [1:0] ReasonRunN = 2'd2;
    localparam logic [1:0] ReasonBkpt = 2'd3;

    localparam int unsigned CtrlSoftRst   = 0;
    localparam int unsigned CtrlRun       = 1;
    localparam int unsigned CtrlStep      = 2;
    localparam int unsigned CtrlRunN      = 3;
    localparam int unsigned CtrlHalt      = 4;
    localparam int unsigned CtrlClrStatus = 5;

    localparam int unsigned StatHaltedBit = 0;
    localparam int unsigned StatReasonLsb = 1;
    localparam int unsigned StatIdxLsb    = 4;

endpackage

// File: rtl/dbg_bkpt_match.sv
// PC breakpoint comparators with a lowest-index-wins priority encoder.
module dbg_bkpt_match #(
    parameter int unsigned NUM_BKPT = 2,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic [NUM_BKPT*PC_WIDTH-1:0] i_bkpt_addr,
    input  logic [NUM_BKPT-1:0]          i_bkpt_en,
    input  logic [PC_WIDTH-1:0]          i_dut_pc,
    output logic                         o_hit,
    output logic [2:0]                   o_idx
);

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_BKPT - 1; i >= 0; i--) begin
            if (i_bkpt_en[i] && (i_bkpt_addr[i*PC_WIDTH +: PC_WIDTH] == i_dut_pc)) begin
                o_hit = 1'b1;
                o_idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/dut_debug_ctrl.sv
// Run/step/run-N clock-enable controller with PC breakpoints, an enabled-cycle
// counter and a registered probe readback mux.
module dut_debug_ctrl
    import dbg_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH           = 32,
    parameter int unsigned NUM_BKPT           = 2,
    parameter int unsigned NUM_PROBES         = 4,
    parameter int unsigned CNT_WIDTH          = 32
) (
    input  logic                                     sysclk,
    input  logic                                     rst,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            ctrl,
    input  logic [CNT_WIDTH-1:0]                     run_n_count,
    input  logic [NUM_BKPT*PC_WIDTH-1:0]             bkpt_addr,
    input  logic [NUM_BKPT-1:0]                      bkpt_en,
    input  logic [$clog2(NUM_PROBES)-1:0]            probe_sel,
    input  logic [PC_WIDTH-1:0]                      dut_pc,
    input  logic [NUM_PROBES*C_S_AXI_DATA_WIDTH-1:0] probe_data,
    output logic                                     dut_clk_en,
    output logic                                     dut_rst,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            status,
    output logic [CNT_WIDTH-1:0]                     cycle_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            probe_out
);

    dbg_state_e                    r_state;
    logic                          r_prev_step;
    logic                          r_prev_runn;
    logic                          r_prev_clr;
    logic                          r_just_left;
    logic [1:0]                    r_reason;
    logic [2:0]                    r_bkpt_idx;
    logic [CNT_WIDTH-1:0]          r_remaining;
    logic [CNT_WIDTH-1:0]          r_cycle_count;
    logic                          r_dut_rst;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_probe_out;

    logic                          w_soft_rst;
    logic                          w_run;
    logic                          w_halt;
    logic                          w_step_edge;
    logic                          w_runn_edge;
    logic                          w_clr_edge;
    logic                          w_bkpt_hit;
    logic [2:0]                    w_bkpt_idx;
    logic                          w_hit;
    logic                          w_clk_en;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_probe_mux;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_status;
    logic                          w_unused_ctrl;

    assign w_soft_rst    = ctrl[CtrlSoftRst];
    assign w_run         = ctrl[CtrlRun];
    assign w_halt        = ctrl[CtrlHalt];
    assign w_step_edge   = ctrl[CtrlStep] & ~r_prev_step;
    assign w_runn_edge   = ctrl[CtrlRunN] & ~r_prev_runn;
    assign w_clr_edge    = ctrl[CtrlClrStatus] & ~r_prev_clr;
    assign w_unused_ctrl = ^ctrl[C_S_AXI_DATA_WIDTH-1:CtrlClrStatus+1];

    dbg_bkpt_match #(
        .NUM_BKPT (NUM_BKPT),
        .PC_WIDTH (PC_WIDTH)
    ) u_bkpt_match (
        .i_bkpt_addr (bkpt_addr),
        .i_bkpt_en   (bkpt_en),
        .i_dut_pc    (dut_pc),
        .o_hit       (w_bkpt_hit),
        .o_idx       (w_bkpt_idx)
    );

    // Steps ignore breakpoints; the first cycle after resuming never matches so
    // a core parked on a breakpoint can move off it.
    assign w_hit = w_bkpt_hit & ~r_just_left & ((r_state == StRun) | (r_state == StRunN));
    assign w_clk_en = (r_state != StHalt) & ~w_hit & ~rst;

    always_comb begin
        w_probe_mux = '0;
        for (int i = 0; i < int'(NUM_PROBES); i++) begin
            if (int'(probe_sel) == i) begin
                w_probe_mux = probe_data[i*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_status                           = '0;
        w_status[StatHaltedBit]            = (r_state == StHalt);
        w_status[StatReasonLsb +: 2]       = r_reason;
        w_status[StatIdxLsb +: 3]          = r_bkpt_idx;
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state       <= StHalt;
            r_prev_step   <= 1'b0;
            r_prev_runn   <= 1'b0;
            r_prev_clr    <= 1'b0;
            r_just_left   <= 1'b0;
            r_reason      <= ReasonNone;
            r_bkpt_idx    <= '0;
            r_remaining   <= '0;
            r_cycle_count <= '0;
            r_dut_rst     <= 1'b1;
            r_probe_out   <= '0;
        end else begin
            r_prev_step <= ctrl[CtrlStep];
            r_prev_runn <= ctrl[CtrlRunN];
            r_prev_clr  <= ctrl[CtrlClrStatus];
            r_dut_rst   <= w_soft_rst;
            r_probe_out <= w_probe_mux;
            r_just_left <= 1'b0;

            if (w_clk_en) begin
                r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
            end
            if (w_clr_edge) begin
                r_reason   <= ReasonNone;
                r_bkpt_idx <= '0;
            end

            if (w_soft_rst) begin
                r_state       <= StHalt;
                r_reason      <= ReasonNone;
                r_bkpt_idx    <= '0;
                r_remaining   <= '0;
                r_cycle_count <= '0;
            end else if (w_halt) begin
                if (r_state != StHalt) begin
                    r_state     <= StHalt;
                    r_reason    <= ReasonNone;
                    r_remaining <= '0;
                end
            end else begin
                unique case (r_state)
                    StHalt: begin
                        if (w_step_edge) begin
                            r_state     <= StStep;
                            r_just_left <= 1'b1;
                        end else if (w_runn_edge) begin
                            if (run_n_count != '0) begin
                                r_state     <= StRunN;
                                r_remaining <= run_n_count;
                                r_just_left <= 1'b1;
                            end
                        end else if (w_run) begin
                            r_state     <= StRun;
                            r_just_left <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (w_hit) begin
                            r_state    <= StHalt;
                            r_reason   <= ReasonBkpt;
                            r_bkpt_idx <= w_bkpt_idx;
                        end else if (!w_run) begin
                            r_state  <= StHalt;
                            r_reason <= ReasonNone;
                        end
                    end
                    StRunN: begin
                        if (w_hit) begin
                            r_state     <= StHalt;
                            r_reason    <= ReasonBkpt;
                            r_bkpt_idx  <= w_bkpt_idx;
                            r_remaining <= '0;
                        end else if (r_remaining == CNT_WIDTH'(1)) begin
                            r_state     <= StHalt;
                            r_reason    <= ReasonRunN;
                            r_remaining <= '0;
                        end else begin
                            r_remaining <= r_remaining - CNT_WIDTH'(1);
                        end
                    end
                    StStep: begin
                        r_state  <= StHalt;
                        r_reason <= ReasonStep;
                    end
                    default: r_state <= StHalt;
                endcase
            end
        end
    end

    assign dut_clk_en  = w_clk_en;
    assign dut_rst     = r_dut_rst;
    assign status      = w_status;
    assign cycle_count = r_cycle_count;
    assign probe_out   = r_probe_out;

endmodule

// File: tb/tb_dut_debug_ctrl.sv
// Directed bench for dut_debug_ctrl: per-cycle vector table plus run-N,
// breakpoint, reset and probe-latency sequences against a simple PC model.
module tb_dut_debug_ctrl;

    logic         sysclk = 1'b0;
    logic         rst;
    logic [31:0]  ctrl;
    logic [31:0]  run_n_count;
    logic [63:0]  bkpt_addr;
    logic [1:0]   bkpt_en;
    logic [1:0]   probe_sel;
    logic [31:0]  dut_pc;
    logic [127:0] probe_data;
    logic         dut_clk_en;
    logic         dut_rst;
    logic [31:0]  status;
    logic [31:0]  cycle_count;
    logic [31:0]  probe_out;

    logic [31:0]  pc = '0;
    int           n_tests = 0;
    int           n_fail = 0;

    typedef struct {
        logic [31:0] ctrl;
        logic [1:0]  sel;
        logic        exp_en;
        logic        exp_rst;
        logic [31:0] exp_status;
        logic [31:0] exp_cnt;
        logic [31:0] exp_probe;
    } vec_t;

    vec_t vecs[19];

    always #5 sysclk = ~sysclk;

    // Behavioural stand-in for the core's PC: advances by 4 per enabled cycle.
    always @(posedge sysclk) begin
        if (dut_rst === 1'b1) pc <= '0;
        else if (dut_clk_en === 1'b1) pc <= pc + 32'd4;
    end
    assign dut_pc = pc;

    dut_debug_ctrl u_dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .ctrl        (ctrl),
        .run_n_count (run_n_count),
        .bkpt_addr   (bkpt_addr),
        .bkpt_en     (bkpt_en),
        .probe_sel   (probe_sel),
        .dut_pc      (dut_pc),
        .probe_data  (probe_data),
        .dut_clk_en  (dut_clk_en),
        .dut_rst     (dut_rst),
        .status      (status),
        .cycle_count (cycle_count),
        .probe_out   (probe_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_halt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge sysclk);
            if (status[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en;
        bit seen;
        bit ok;

        vecs[0]  = '{32'h04, 2'd0, 1'b1, 1'b0, 32'h0, 32'd0, 32'h1111_1111};
        vecs[1]  = '{32'h00, 2'd1, 1'b0, 1'b0, 32'h3, 32'd1, 32'h2222_2222};
        vecs[2]  = '{32'h04, 2'd2, 1'b1, 1'b0, 32'h2, 32'd1, 32'hDEAD_BEEF};
        vecs[3]  = '{32'h00, 2'd3, 1'b0, 1'b0, 32'h3, 32'd2, 32'h4444_4444};
        vecs[4]  = '{32'h04, 2'd0, 1'b1, 1'b0, 32'h2, 32'd2, 32'h1111_1111};
        vecs[5]  = '{32'h00, 2'd1, 1'b0, 1'b0, 32'h3, 32'd3, 32'h2222_2222};
        vecs[6]  = '{32'h20, 2'd2, 1'b0, 1'b0, 32'h1, 32'd3, 32'hDEAD_BEEF};
        vecs[7]  = '{32'h00, 2'd2, 1'b0, 1'b0, 32'h1, 32'd3, 32'hDEAD_BEEF};
        vecs[8]  = '{32'h14, 2'd0, 1'b0, 1'b0, 32'h1, 32'd3, 32'h1111_1111};
        vecs[9]  = '{32'h00, 2'd0, 1'b0, 1'b0, 32'h1, 32'd3, 32'h1111_1111};
        vecs[10] = '{32'h08, 2'd1, 1'b0, 1'b0, 32'h1, 32'd3, 32'h2222_2222};
        vecs[11] = '{32'h00, 2'd1, 1'b0, 1'b0, 32'h1, 32'd3, 32'h2222_2222};
        vecs[12] = '{32'h02, 2'd3, 1'b1, 1'b0, 32'h0, 32'd3, 32'h4444_4444};
        vecs[13] = '{32'h02, 2'd3, 1'b1, 1'b0, 32'h0, 32'd4, 32'h4444_4444};
        vecs[14] = '{32'h12, 2'd0, 1'b0, 1'b0, 32'h1, 32'd5, 32'h1111_1111};
        vecs[15] = '{32'h00, 2'd0, 1'b0, 1'b0, 32'h1, 32'd5, 32'h1111_1111};
        vecs[16] = '{32'h02, 2'd2, 1'b1, 1'b0, 32'h0, 32'd5, 32'hDEAD_BEEF};
        vecs[17] = '{32'h03, 2'd2, 1'b0, 1'b1, 32'h1, 32'd0, 32'hDEAD_BEEF};
        vecs[18] = '{32'h00, 2'd2, 1'b0, 1'b0, 32'h1, 32'd0, 32'hDEAD_BEEF};

        rst         = 1'b1;
        ctrl        = '0;
        run_n_count = '0;
        bkpt_addr   = '0;
        bkpt_en     = '0;
        probe_sel   = '0;
        probe_data  = {32'h4444_4444, 32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111};

        // Reset held for three cycles.
        repeat (3) @(negedge sysclk);
        chk("rst_clk_en", {31'd0, dut_clk_en}, 32'd0);
        chk("rst_status", status, 32'h1);
        chk("rst_cycle_count", cycle_count, 32'd0);
        chk("rst_dut_rst", {31'd0, dut_rst}, 32'd1);
        chk("rst_probe_out", probe_out, 32'd0);
        rst = 1'b0;
        @(negedge sysclk);
        chk("post_rst_dut_rst", {31'd0, dut_rst}, 32'd0);

        // Steps, clear, halt-vs-step priority, run_n with zero, run/halt, soft reset.
        foreach (vecs[i]) begin
            ctrl      = vecs[i].ctrl;
            probe_sel = vecs[i].sel;
            @(negedge sysclk);
            chk($sformatf("vec%0d_clk_en", i), {31'd0, dut_clk_en}, {31'd0, vecs[i].exp_en});
            chk($sformatf("vec%0d_dut_rst", i), {31'd0, dut_rst}, {31'd0, vecs[i].exp_rst});
            chk($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
            chk($sformatf("vec%0d_cycle_count", i), cycle_count, vecs[i].exp_cnt);
            chk($sformatf("vec%0d_probe_out", i), probe_out, vecs[i].exp_probe);
        end

        // Run-N of 10; count is sampled only on the edge.
        n_en = 0;
        seen = 1'b0;
        ctrl = 32'h08;
        run_n_count = 32'd10;
        for (int i = 0; i < 25; i++) begin
            @(negedge sysclk);
            if (i == 0) begin
                ctrl = '0;
                run_n_count = 32'd99;
            end
            if (dut_clk_en === 1'b1) begin
                n_en++;
            end else if (n_en > 0 && !seen) begin
                seen = 1'b1;
                chk("runn_done_status", status, 32'h5);
            end
        end
        chk("runn_enabled_cycles", n_en, 32'd10);
        chk("runn_cycle_count", cycle_count, 32'd10);
        chk("runn_halt_seen", {31'd0, seen}, 32'd1);

        // Soft reset clears the counter and the PC model.
        ctrl = 32'h01;
        @(negedge sysclk);
        ctrl = '0;
        repeat (2) @(negedge sysclk);
        chk("softrst_cycle_count", cycle_count, 32'd0);

        // Breakpoint 0 at 0x10.
        bkpt_addr = {32'h0000_0000, 32'h0000_0010};
        bkpt_en   = 2'b01;
        ctrl      = 32'h02;
        wait_halt(ok);
        ctrl = '0;
        chk("bkpt0_halted", {31'd0, ok}, 32'd1);
        chk("bkpt0_pc", dut_pc, 32'h10);
        chk("bkpt0_cycle_count", cycle_count, 32'd4);
        chk("bkpt0_status", status, 32'h7);

        // Resume from the breakpoint must advance past it.
        ctrl = 32'h02;
        repeat (3) @(negedge sysclk);
        ctrl = '0;
        @(negedge sysclk);
        chk("resume_pc", dut_pc, 32'h1C);
        chk("resume_status", status, 32'h1);
        chk("resume_cycle_count", cycle_count, 32'd7);

        // Breakpoint 1 only; index reported in the status word.
        bkpt_addr = {32'h0000_0024, 32'h0000_0010};
        bkpt_en   = 2'b10;
        ctrl      = 32'h02;
        wait_halt(ok);
        ctrl = '0;
        chk("bkpt1_halted", {31'd0, ok}, 32'd1);
        chk("bkpt1_pc", dut_pc, 32'h24);
        chk("bkpt1_status", status, 32'h17);
        chk("bkpt1_cycle_count", cycle_count, 32'd9);

        // rst in the middle of a long run-N.
        bkpt_en = '0;
        ctrl = 32'h08;
        run_n_count = 32'd50;
        @(negedge sysclk);
        ctrl = '0;
        repeat (2) @(negedge sysclk);
        chk("runn50_running", {31'd0, dut_clk_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_gates_clk_en", {31'd0, dut_clk_en}, 32'd0);
        @(negedge sysclk);
        chk("midrst_status", status, 32'h1);
        chk("midrst_cycle_count", cycle_count, 32'd0);
        chk("midrst_dut_rst", {31'd0, dut_rst}, 32'd1);
        chk("midrst_probe_out", probe_out, 32'd0);
        rst = 1'b0;
        n_en = 0;
        repeat (5) begin
            @(negedge sysclk);
            if (dut_clk_en === 1'b1) n_en++;
        end
        chk("midrst_no_resume", n_en, 32'd0);

        // Probe readback lags select/data by one cycle.
        probe_sel = 2'd2;
        @(negedge sysclk);
        chk("probe_sel2", probe_out, 32'hDEAD_BEEF);
        probe_data[95:64] = 32'h1234_5678;
        #1;
        chk("probe_hold", probe_out, 32'hDEAD_BEEF);
        @(negedge sysclk);
        chk("probe_update", probe_out, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
